// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile_nr2w1 register file.
package regfile_pkg;

  localparam int REGFILE_WIDTH    = 32;
  localparam int REGFILE_NUM_REGS = 16;

  // An address names a real, writable register: in range and not a hardwired r0.
  function automatic logic addr_valid(
    input int unsigned addr,
    input int unsigned num_regs,
    input bit          r0_zero
  );
    logic ok;
    if (addr >= num_regs) begin
      ok = 1'b0;
    end else if (r0_zero && (addr == 32'd0)) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: storage mux, write bypass and busy select.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter bit R0_ZERO  = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter int AW       = $clog2(REGFILE_NUM_REGS)
) (
  input  logic [AW-1:0]                     ra_i,
  input  logic [NUM_REGS-1:0][WIDTH-1:0]    mem_i,
  input  logic [NUM_REGS-1:0]               busy_vec_i,
  input  logic                              wr_ok_i,
  input  logic [AW-1:0]                     wa_i,
  input  logic [WIDTH-1:0]                  wd_i,
  output logic [WIDTH-1:0]                  rd_o,
  output logic                              busy_o
);

  logic ra_ok_s;
  logic hit_s;

  assign ra_ok_s = addr_valid(32'(ra_i), NUM_REGS, R0_ZERO);
  // A write only forwards when it is itself accepted, so an ignored write never leaks through.
  assign hit_s   = BYPASS && wr_ok_i && (wa_i == ra_i);

  // Select read data: invalid addresses read 0, a same-cycle write forwards, else storage.
  always_comb begin
    rd_o = {WIDTH{1'b0}};
    if (!ra_ok_s) begin
      rd_o = {WIDTH{1'b0}};
    end else if (hit_s) begin
      rd_o = wd_i;
    end else begin
      rd_o = mem_i[ra_i];
    end
  end

  // Select busy: a forwarded write satisfies the consumer this cycle.
  always_comb begin
    busy_o = 1'b0;
    if (!ra_ok_s) begin
      busy_o = 1'b0;
    end else if (hit_s) begin
      busy_o = 1'b0;
    end else begin
      busy_o = busy_vec_i[ra_i];
    end
  end

endmodule

// File: rtl/regfile_nr2w1.sv
// Parametrised register file: two combinational read ports, one write port,
// and a per-register busy scoreboard (reserve at decode, release at writeback).
module regfile_nr2w1
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter bit R0_ZERO  = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [WIDTH-1:0]    wd,
  input  logic [AW-1:0]       ra_a,
  output logic [WIDTH-1:0]    rd_a,
  output logic                busy_a,
  input  logic [AW-1:0]       ra_b,
  output logic [WIDTH-1:0]    rd_b,
  output logic                busy_b,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0][WIDTH-1:0] mem_q;
  logic [NUM_REGS-1:0][WIDTH-1:0] mem_d;
  logic [NUM_REGS-1:0]            busy_q;
  logic [NUM_REGS-1:0]            busy_d;
  logic                           wr_ok_s;
  logic                           rsv_ok_s;

  assign wr_ok_s  = we     && addr_valid(32'(wa), NUM_REGS, R0_ZERO);
  assign rsv_ok_s = rsv_en && addr_valid(32'(rsv_addr), NUM_REGS, R0_ZERO);

  // Next-state storage and scoreboard; a reserve to the register being written wins.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_ok_s && (wa == AW'(i))) begin
        mem_d[i] = wd;
      end else begin
        mem_d[i] = mem_q[i];
      end
      if (rsv_ok_s && (rsv_addr == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wr_ok_s && (wa == AW'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // State register with synchronous active-low reset overriding write and reserve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  regfile_read_port #(
    .WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .R0_ZERO(R0_ZERO), .BYPASS(BYPASS), .AW(AW)
  ) u_port_a (
    .ra_i(ra_a), .mem_i(mem_q), .busy_vec_i(busy_q), .wr_ok_i(wr_ok_s),
    .wa_i(wa), .wd_i(wd), .rd_o(rd_a), .busy_o(busy_a)
  );

  regfile_read_port #(
    .WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .R0_ZERO(R0_ZERO), .BYPASS(BYPASS), .AW(AW)
  ) u_port_b (
    .ra_i(ra_b), .mem_i(mem_q), .busy_vec_i(busy_q), .wr_ok_i(wr_ok_s),
    .wa_i(wa), .wd_i(wd), .rd_o(rd_b), .busy_o(busy_b)
  );

endmodule

// File: tb/tb_regfile_nr2w1.sv
// Directed bench: a default 16x32 instance and a 12-entry no-bypass instance
// share one stimulus stream; expected values are hand-computed constants.
module tb_regfile_nr2w1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic [3:0]  ra_a;
  logic [3:0]  ra_b;
  logic        rsv_en;
  logic [3:0]  rsv_addr;

  logic [31:0] rd_a, rd_b;
  logic        busy_a, busy_b;
  logic [15:0] busy_vec;

  logic [31:0] rd_a12, rd_b12;
  logic        busy_a12, busy_b12;
  logic [11:0] busy_vec12;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_nr2w1 dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra_a(ra_a), .rd_a(rd_a), .busy_a(busy_a),
    .ra_b(ra_b), .rd_b(rd_b), .busy_b(busy_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  regfile_nr2w1 #(.NUM_REGS(12), .BYPASS(1'b0)) dut12 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra_a(ra_a), .rd_a(rd_a12), .busy_a(busy_a12),
    .ra_b(ra_b), .rd_b(rd_b12), .busy_b(busy_b12),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec12)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; rsv_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wa = 4'd0; wd = 32'h0;
    ra_a = 4'd0; ra_b = 4'd0; rsv_en = 1'b0; rsv_addr = 4'd0;
    tick(); tick();
    rst_n = 1'b1;

    // reset state on every address, both ports
    for (int i = 0; i < 16; i++) begin
      ra_a = 4'(i); ra_b = 4'(15 - i); #1;
      check_eq("rst_rd_a", 64'(rd_a), 64'h0);
      check_eq("rst_rd_b", 64'(rd_b), 64'h0);
    end
    check_eq("rst_busy_vec", 64'(busy_vec), 64'h0);
    check_eq("rst_busy_vec12", 64'(busy_vec12), 64'h0);

    // plain write then read
    we = 1'b1; wa = 4'd5; wd = 32'hDEADBEEF;
    tick(); idle();
    ra_a = 4'd5; ra_b = 4'd5; #1;
    check_eq("wr_rd_a", 64'(rd_a), 64'hDEADBEEF);
    check_eq("wr_rd_b", 64'(rd_b), 64'hDEADBEEF);
    check_eq("wr_busy_a", 64'(busy_a), 64'h0);
    check_eq("wr_busy_b", 64'(busy_b), 64'h0);
    check_eq("wr_rd_a12", 64'(rd_a12), 64'hDEADBEEF);

    // r0 is hardwired zero
    we = 1'b1; wa = 4'd0; wd = 32'hFFFFFFFF;
    tick(); idle();
    ra_a = 4'd0; #1;
    check_eq("r0_rd_a", 64'(rd_a), 64'h0);

    // bypass vs no bypass, before the edge
    ra_b = 4'd3; we = 1'b1; wa = 4'd3; wd = 32'h12345678; #1;
    check_eq("byp_rd_b", 64'(rd_b), 64'h12345678);
    check_eq("nobyp_rd_b12", 64'(rd_b12), 64'h0);
    tick(); idle(); #1;
    check_eq("nobyp_after_rd_b12", 64'(rd_b12), 64'h12345678);

    // reserve then release
    rsv_en = 1'b1; rsv_addr = 4'd7;
    tick(); idle();
    ra_a = 4'd7; #1;
    check_eq("rsv_busy_vec", 64'(busy_vec), 64'h0080);
    check_eq("rsv_busy_vec12", 64'(busy_vec12), 64'h080);
    check_eq("rsv_busy_a", 64'(busy_a), 64'h1);
    we = 1'b1; wa = 4'd7; wd = 32'h00000077; #1;
    check_eq("rel_byp_busy_a", 64'(busy_a), 64'h0);
    check_eq("rel_nobyp_busy_a12", 64'(busy_a12), 64'h1);
    tick(); idle(); #1;
    check_eq("rel_busy_vec", 64'(busy_vec), 64'h0);
    check_eq("rel_busy_vec12", 64'(busy_vec12), 64'h0);

    // collision: write and reserve the same register
    ra_b = 4'd9; we = 1'b1; wa = 4'd9; wd = 32'hA5A5A5A5;
    rsv_en = 1'b1; rsv_addr = 4'd9; #1;
    check_eq("col_same_cycle_busy_b", 64'(busy_b), 64'h0);
    tick(); idle(); #1;
    check_eq("col_rd_b", 64'(rd_b), 64'hA5A5A5A5);
    check_eq("col_busy_b", 64'(busy_b), 64'h1);
    check_eq("col_busy_vec", 64'(busy_vec), 64'h0200);
    check_eq("col_rd_b12", 64'(rd_b12), 64'hA5A5A5A5);

    // write and reserve different registers
    we = 1'b1; wa = 4'd2; wd = 32'h22222222; rsv_en = 1'b1; rsv_addr = 4'd4;
    tick(); idle();
    ra_a = 4'd2; #1;
    check_eq("diff_rd_a", 64'(rd_a), 64'h22222222);
    check_eq("diff_busy_vec", 64'(busy_vec), 64'h0210);
    check_eq("diff_busy_vec12", 64'(busy_vec12), 64'h210);

    // reserving r0 is ignored
    rsv_en = 1'b1; rsv_addr = 4'd0;
    tick(); idle();
    ra_a = 4'd0; #1;
    check_eq("r0_rsv_busy_vec", 64'(busy_vec), 64'h0210);
    check_eq("r0_rsv_busy_a", 64'(busy_a), 64'h0);

    // address 13: valid for 16 entries, out of range for 12
    we = 1'b1; wa = 4'd13; wd = 32'hCAFEF00D; rsv_en = 1'b1; rsv_addr = 4'd13;
    tick(); idle();
    ra_a = 4'd13; ra_b = 4'd12; #1;
    check_eq("oor16_rd_a", 64'(rd_a), 64'hCAFEF00D);
    check_eq("oor16_busy_a", 64'(busy_a), 64'h1);
    check_eq("oor16_busy_vec", 64'(busy_vec), 64'h2210);
    check_eq("oor12_rd_a", 64'(rd_a12), 64'h0);
    check_eq("oor12_busy_a", 64'(busy_a12), 64'h0);
    check_eq("oor12_busy_vec", 64'(busy_vec12), 64'h210);
    check_eq("oor12_rd_b", 64'(rd_b12), 64'h0);
    check_eq("oor12_busy_b", 64'(busy_b12), 64'h0);

    // reset mid-operation overrides write and reserve
    rst_n = 1'b0; we = 1'b1; wa = 4'd6; wd = 32'h11111111;
    rsv_en = 1'b1; rsv_addr = 4'd6;
    tick();
    rst_n = 1'b1; idle(); #1;
    check_eq("mrst_busy_vec", 64'(busy_vec), 64'h0);
    check_eq("mrst_busy_vec12", 64'(busy_vec12), 64'h0);
    for (int i = 0; i < 16; i++) begin
      ra_a = 4'(i); ra_b = 4'(i); #1;
      check_eq("mrst_rd_a", 64'(rd_a), 64'h0);
      check_eq("mrst_rd_b12", 64'(rd_b12), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
